// File: rtl/fft_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fft_rr_scheduler
//
// Shares one parallel-frame FFT core among NUM_CH channels. Each cycle a
// round-robin arbiter picks one channel that has a full frame ready and
// forwards that frame straight to the FFT core, with no buffering. The
// channel ID of every issued frame is pushed into a tag FIFO. Results come
// back from the core in issue order, so the FIFO head names the channel
// that owns the current result.
//
// Handshake rule on every val/rdy pair in this block: a transfer happens on
// a rising clk edge where val && rdy. A producer holding val high keeps its
// message stable until that transfer. fft_send_val never looks at
// fft_send_rdy, and it never looks at anything on the fft_recv_* side.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   reset         asynchronous, active-low reset
//   ch_recv_msg   NUM_CH input frames; channel c at [c*FW +: FW]
//   ch_recv_val   channel c has a frame valid
//   ch_recv_rdy   frame from channel c is accepted this cycle
//   fft_send_msg  frame to the FFT core
//   fft_send_val  frame valid to the FFT core
//   fft_send_rdy  FFT core can take a frame
//   fft_recv_msg  result frame from the FFT core
//   fft_recv_val  result valid from the FFT core
//   fft_recv_rdy  result taken by the owning channel
//   ch_send_msg   result frame, broadcast to all channels
//   ch_send_val   result valid for channel c (one-hot or zero)
//   ch_send_rdy   channel c can take a result
//   inflight      tag FIFO occupancy
//   err_orphan    sticky: a result arrived while no tag was pending
// ---------------------------------------------------------------------------
module fft_rr_scheduler #(
    parameter int BIT_WIDTH    = 32,
    parameter int N_SAMPLES    = 8,
    parameter int NUM_CH       = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CH*N_SAMPLES*BIT_WIDTH-1:0]   ch_recv_msg,
    input  logic [NUM_CH-1:0]                       ch_recv_val,
    output logic [NUM_CH-1:0]                       ch_recv_rdy,
    output logic [N_SAMPLES*BIT_WIDTH-1:0]          fft_send_msg,
    output logic                                    fft_send_val,
    input  logic                                    fft_send_rdy,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0]          fft_recv_msg,
    input  logic                                    fft_recv_val,
    output logic                                    fft_recv_rdy,
    output logic [N_SAMPLES*BIT_WIDTH-1:0]          ch_send_msg,
    output logic [NUM_CH-1:0]                       ch_send_val,
    input  logic [NUM_CH-1:0]                       ch_send_rdy,
    output logic [$clog2(MAX_INFLIGHT):0]           inflight,
    output logic                                    err_orphan
);

    localparam int FW    = BIT_WIDTH * N_SAMPLES;
    localparam int CW    = $clog2(NUM_CH);
    localparam int CW1   = CW + 1;
    localparam int PW    = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PW + 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CW-1:0]    rr_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CW-1:0]    tag_mem [MAX_INFLIGHT];

    logic [CW-1:0]    grant;
    logic             any_val;
    logic [CW1-1:0]   idx_ext;
    logic [CW-1:0]    head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full     = (count == CNT_W'(MAX_INFLIGHT));
    assign empty    = (count == '0);
    assign head     = tag_mem[rd_ptr];
    assign inflight = count;

    // -----------------------------------------------------------------------
    // Round-robin arbiter: scan rr_ptr, rr_ptr+1, ... mod NUM_CH and take the
    // first valid channel. The sum is one bit wider so the wrap can be done
    // with a single compare-and-subtract for any NUM_CH, not just powers of 2.
    // -----------------------------------------------------------------------
    always_comb begin
        grant   = '0;
        any_val = 1'b0;
        idx_ext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_ext = {1'b0, rr_ptr} + CW1'(i);
            if (idx_ext >= CW1'(NUM_CH)) begin
                idx_ext = idx_ext - CW1'(NUM_CH);
            end
            if (!any_val && ch_recv_val[idx_ext[CW-1:0]]) begin
                grant   = idx_ext[CW-1:0];
                any_val = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Issue side. The reset term keeps every val/rdy output low while reset
    // is held, even if channels keep their valids up.
    // -----------------------------------------------------------------------
    assign fft_send_val = reset && any_val && !full;
    assign push         = fft_send_val && fft_send_rdy;

    // With no channel valid, grant stays 0, so channel 0 is driven.
    always_comb begin
        fft_send_msg = ch_recv_msg[0 +: FW];
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant == CW'(c)) begin
                fft_send_msg = ch_recv_msg[c*FW +: FW];
            end
        end
    end

    always_comb begin
        ch_recv_rdy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_recv_rdy[c] = (grant == CW'(c)) && push;
        end
    end

    // -----------------------------------------------------------------------
    // Return side: the FIFO head owns the result on fft_recv_*.
    // -----------------------------------------------------------------------
    assign fft_recv_rdy = !empty && ch_send_rdy[head];
    assign pop          = fft_recv_val && fft_recv_rdy;
    assign ch_send_msg  = fft_recv_msg;

    always_comb begin
        ch_send_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_send_val[c] = fft_recv_val && !empty && (head == CW'(c));
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (grant == CW'(NUM_CH - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push is already blocked when full, so no bypass case exists.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fft_recv_val && empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_fft_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fft_rr_scheduler
//
// Directed bench for fft_rr_scheduler with default parameters (4 channels,
// 8 x 32-bit samples, 4 frames in flight). The bench plays the FFT core by
// hand on fft_send_rdy / fft_recv_*. Inputs change 1 ns after a rising
// edge and outputs are checked 1 ns after that.
// ---------------------------------------------------------------------------
module tb_fft_rr_scheduler;

    localparam int BW = 32;
    localparam int NS = 8;
    localparam int NC = 4;
    localparam int MI = 4;
    localparam int FW = BW * NS;

    logic              clk;
    logic              reset;
    logic [NC*FW-1:0]  ch_recv_msg;
    logic [NC-1:0]     ch_recv_val;
    logic [NC-1:0]     ch_recv_rdy;
    logic [FW-1:0]     fft_send_msg;
    logic              fft_send_val;
    logic              fft_send_rdy;
    logic [FW-1:0]     fft_recv_msg;
    logic              fft_recv_val;
    logic              fft_recv_rdy;
    logic [FW-1:0]     ch_send_msg;
    logic [NC-1:0]     ch_send_val;
    logic [NC-1:0]     ch_send_rdy;
    logic [2:0]        inflight;
    logic              err_orphan;

    int vectors;
    int miscompares;

    logic [FW-1:0] exp_frame [NC];
    logic [FW-1:0] res_frame;
    int            exp_order [5];

    fft_rr_scheduler #(
        .BIT_WIDTH    (BW),
        .N_SAMPLES    (NS),
        .NUM_CH       (NC),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_recv_msg  (ch_recv_msg),
        .ch_recv_val  (ch_recv_val),
        .ch_recv_rdy  (ch_recv_rdy),
        .fft_send_msg (fft_send_msg),
        .fft_send_val (fft_send_val),
        .fft_send_rdy (fft_send_rdy),
        .fft_recv_msg (fft_recv_msg),
        .fft_recv_val (fft_recv_val),
        .fft_recv_rdy (fft_recv_rdy),
        .ch_send_msg  (ch_send_msg),
        .ch_send_val  (ch_send_val),
        .ch_send_rdy  (ch_send_rdy),
        .inflight     (inflight),
        .err_orphan   (err_orphan)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame whose sample k holds base+k.
    function automatic logic [FW-1:0] mk_frame(input int base);
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < NS; k++) begin
            r[k*BW +: BW] = BW'(base + k);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_order   = '{0, 1, 2, 3, 0};
        exp_frame[0] = mk_frame(10);
        exp_frame[1] = mk_frame(20);
        exp_frame[2] = mk_frame(1);
        exp_frame[3] = mk_frame(40);

        reset        = 1'b0;
        ch_recv_msg  = '0;
        ch_recv_val  = '0;
        fft_send_rdy = 1'b0;
        fft_recv_msg = '0;
        fft_recv_val = 1'b0;
        ch_send_rdy  = '0;
        for (int c = 0; c < NC; c++) begin
            ch_recv_msg[c*FW +: FW] = exp_frame[c];
        end

        // ---------------- reset state ----------------
        settle();
        chk("rst_inflight",     FW'(inflight),     FW'(0));
        chk("rst_err_orphan",   FW'(err_orphan),   FW'(0));
        chk("rst_fft_send_val", FW'(fft_send_val), FW'(0));
        chk("rst_fft_recv_rdy", FW'(fft_recv_rdy), FW'(0));
        chk("rst_ch_send_val",  FW'(ch_send_val),  FW'(0));
        chk("rst_ch_recv_rdy",  FW'(ch_recv_rdy),  FW'(0));
        tick();
        reset = 1'b1;

        // ---------------- single channel 2 ----------------
        ch_recv_val  = 4'b0100;
        fft_send_rdy = 1'b1;
        settle();
        chk("single_send_val", FW'(fft_send_val), FW'(1));
        chk("single_send_msg", fft_send_msg,      mk_frame(1));
        chk("single_recv_rdy", FW'(ch_recv_rdy),  FW'(4'b0100));
        tick();
        ch_recv_val  = '0;
        fft_send_rdy = 1'b0;
        settle();
        chk("single_inflight1", FW'(inflight), FW'(1));
        res_frame    = mk_frame(100);
        fft_recv_val = 1'b1;
        fft_recv_msg = res_frame;
        ch_send_rdy  = 4'b1111;
        settle();
        chk("single_ch_send_val", FW'(ch_send_val),  FW'(4'b0100));
        chk("single_fft_recv_rdy", FW'(fft_recv_rdy), FW'(1));
        chk("single_ch_send_msg", ch_send_msg,       res_frame);
        tick();
        fft_recv_val = 1'b0;
        settle();
        chk("single_inflight0", FW'(inflight), FW'(0));

        // rr_ptr is now 3: with channels 0 and 3 valid, channel 3 wins.
        ch_recv_val = 4'b1001;
        settle();
        chk("rrptr3_msg",      fft_send_msg,     mk_frame(40));
        chk("rrptr3_rdy_low",  FW'(ch_recv_rdy), FW'(0));
        fft_send_rdy = 1'b1;
        settle();
        chk("rrptr3_recv_rdy", FW'(ch_recv_rdy), FW'(4'b1000));
        tick();
        ch_recv_val  = '0;
        fft_send_rdy = 1'b0;
        fft_recv_val = 1'b1;
        fft_recv_msg = mk_frame(200);
        settle();
        chk("rrptr3_ret_val", FW'(ch_send_val), FW'(4'b1000));
        tick();
        fft_recv_val = 1'b0;
        settle();
        chk("rrptr3_inflight0", FW'(inflight), FW'(0));

        // ---------------- all channels valid, rr_ptr = 0 ----------------
        ch_recv_val  = 4'b1111;
        fft_send_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("rr_grant%0d", k), FW'(ch_recv_rdy), FW'(4'b0001 << exp_order[k]));
            chk($sformatf("rr_msg%0d", k),   fft_send_msg,     exp_frame[exp_order[k]]);
            tick();
        end
        settle();
        chk("full_inflight",  FW'(inflight),     FW'(4));
        chk("full_stall_val", FW'(fft_send_val), FW'(0));
        chk("full_stall_rdy", FW'(ch_recv_rdy),  FW'(0));

        // ---------------- full FIFO, pop in same cycle as request ----------------
        fft_recv_val = 1'b1;
        fft_recv_msg = mk_frame(300);
        settle();
        chk("fullpop_recv_rdy", FW'(fft_recv_rdy), FW'(1));
        chk("fullpop_send_val", FW'(ch_send_val),  FW'(4'b0001));
        chk("fullpop_no_issue", FW'(fft_send_val), FW'(0));
        tick();
        fft_recv_val = 1'b0;
        settle();
        chk("fullpop_inflight3", FW'(inflight),    FW'(3));
        chk("fullpop_issue5",    FW'(ch_recv_rdy), FW'(4'b0001 << exp_order[4]));
        chk("fullpop_msg5",      fft_send_msg,     exp_frame[exp_order[4]]);
        tick();
        ch_recv_val  = '0;
        fft_send_rdy = 1'b0;
        settle();
        chk("after5_inflight4", FW'(inflight), FW'(4));

        // ---------------- back-pressure on head tag 2 ----------------
        // FIFO holds 1,2,3,0: retire the tag-1 result first.
        fft_recv_val = 1'b1;
        fft_recv_msg = mk_frame(400);
        settle();
        chk("bp_pre_val", FW'(ch_send_val), FW'(4'b0010));
        tick();
        ch_send_rdy  = 4'b0001;
        fft_recv_msg = mk_frame(500);
        settle();
        chk("bp_inflight3",   FW'(inflight),     FW'(3));
        chk("bp_recv_rdy0",   FW'(fft_recv_rdy), FW'(0));
        chk("bp_send_val",    FW'(ch_send_val),  FW'(4'b0100));
        chk("bp_send_msg",    ch_send_msg,       mk_frame(500));
        tick();
        chk("bp_held_infl",   FW'(inflight),     FW'(3));
        chk("bp_held_val",    FW'(ch_send_val),  FW'(4'b0100));
        ch_send_rdy = 4'b0101;
        settle();
        chk("bp_recv_rdy1",   FW'(fft_recv_rdy), FW'(1));
        tick();
        fft_recv_val = 1'b0;
        settle();
        chk("bp_inflight2",   FW'(inflight),     FW'(2));

        // ---------------- reset mid-traffic with 3 in flight ----------------
        ch_recv_val  = 4'b0010;
        fft_send_rdy = 1'b1;
        settle();
        chk("pre_rst_grant1", FW'(ch_recv_rdy), FW'(4'b0010));
        tick();
        settle();
        chk("pre_rst_inflight3", FW'(inflight), FW'(3));
        fft_recv_val = 1'b1;
        ch_send_rdy  = 4'b1111;
        #2;
        reset = 1'b0;
        settle();
        chk("mid_rst_inflight", FW'(inflight),     FW'(0));
        chk("mid_rst_send_val", FW'(fft_send_val), FW'(0));
        chk("mid_rst_recv_rdy", FW'(ch_recv_rdy),  FW'(0));
        chk("mid_rst_fft_rdy",  FW'(fft_recv_rdy), FW'(0));
        chk("mid_rst_ch_val",   FW'(ch_send_val),  FW'(0));
        chk("mid_rst_orphan",   FW'(err_orphan),   FW'(0));
        tick();
        ch_recv_val  = '0;
        fft_send_rdy = 1'b0;
        fft_recv_val = 1'b0;
        reset        = 1'b1;

        // ---------------- orphan result ----------------
        tick();
        fft_recv_val = 1'b1;
        fft_recv_msg = mk_frame(600);
        settle();
        chk("orphan_recv_rdy", FW'(fft_recv_rdy), FW'(0));
        chk("orphan_ch_val",   FW'(ch_send_val),  FW'(0));
        chk("orphan_pre",      FW'(err_orphan),   FW'(0));
        tick();
        fft_recv_val = 1'b0;
        settle();
        chk("orphan_set",      FW'(err_orphan),   FW'(1));
        repeat (10) tick();
        chk("orphan_sticky",   FW'(err_orphan),   FW'(1));
        chk("orphan_inflight", FW'(inflight),     FW'(0));
        reset = 1'b0;
        settle();
        chk("orphan_cleared",  FW'(err_orphan),   FW'(0));
        tick();
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
